// File: rtl/ahb_ecc_mem_responder.sv
// AHB-Lite word-memory slave with programmable waits, ERROR responses, SECDED read data with bit-flip injection, plus a single-master grant.
// Latency: wait_cfg+1 data-phase cycles (2 for ERROR); backpressure by holding hready low in WAIT/ERR1.
module ahb_ecc_mem_responder #(
    parameter int         MEM_DEPTH = 64,
    parameter int         WAIT_W    = 4,
    parameter logic [3:0] MASTER_ID = 4'd1
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic [31:0]       haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [2:0]        hburst,
    input  logic [63:0]       hwdata,
    input  logic              hbusreq,
    input  logic              hlock,
    input  logic [WAIT_W-1:0] wait_cfg,
    input  logic              err_req,
    input  logic [5:0]        inj_a,
    input  logic [5:0]        inj_b,
    output logic [31:0]       hrdata,
    output logic              hready,
    output logic [1:0]        hresp,
    output logic              hgrant,
    output logic [3:0]        hmaster
);

    localparam int IDX_W = $clog2(MEM_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                hwrite_q, hwrite_d;
    logic [5:0]          inj_a_q, inj_a_d;
    logic [5:0]          inj_b_q, inj_b_d;
    logic                hgrant_q, hgrant_d;
    logic [3:0]          hmaster_q, hmaster_d;
    logic [25:0]         mem_q [MEM_DEPTH];

    logic                accept;
    logic                err_flag;
    logic                rd_vld;
    logic                mem_we;
    logic [31:0]         flip;
    logic                unused_ok;

    assign unused_ok = ^{hburst, htrans[0], haddr[31:IDX_W+2], haddr[1:0], hwdata[63:26]};

    // Hamming layout: parity at power-of-two positions, data fills the rest, position 32 is overall parity.
    function automatic logic [31:0] ecc_encode(input logic [25:0] d);
        logic [31:0] cw;
        logic        p;
        int          k;
        cw = '0;
        k  = 0;
        for (int n = 1; n < 32; n++) begin
            if ((n & (n - 1)) != 0) begin
                cw[n-1] = d[k];
                k++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            p = 1'b0;
            for (int n = 1; n < 32; n++) begin
                if (((n >> i) & 1) == 1) p = p ^ cw[n-1];
            end
            cw[(1 << i) - 1] = p;
        end
        cw[31] = ^cw[30:0];
        return cw;
    endfunction

    function automatic logic [31:0] flip_mask(input logic [5:0] pos);
        logic [31:0] m;
        m = '0;
        if (pos != 6'd0 && pos <= 6'd32) m = 32'd1 << (pos - 6'd1);
        return m;
    endfunction

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            idx_q      <= '0;
            hwrite_q   <= 1'b0;
            inj_a_q    <= '0;
            inj_b_q    <= '0;
            hgrant_q   <= 1'b0;
            hmaster_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            idx_q      <= idx_d;
            hwrite_q   <= hwrite_d;
            inj_a_q    <= inj_a_d;
            inj_b_q    <= inj_b_d;
            hgrant_q   <= hgrant_d;
            hmaster_q  <= hmaster_d;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
        end else if (mem_we) begin
            mem_q[idx_q] <= hwdata[25:0];
        end
    end

    assign accept   = hready & htrans[1];
    assign err_flag = err_req | (hsize != 3'b010);

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        idx_d      = idx_q;
        hwrite_d   = hwrite_q;
        inj_a_d    = inj_a_q;
        inj_b_d    = inj_b_q;
        if (accept) begin
            idx_d      = haddr[IDX_W+1:2];
            hwrite_d   = hwrite;
            inj_a_d    = inj_a;
            inj_b_d    = inj_b;
            wait_cnt_d = wait_cfg;
        end
        case (state_q)
            S_IDLE, S_DATA, S_ERR2: begin
                if (!accept)                 state_d = S_IDLE;
                else if (err_flag)           state_d = S_ERR1;
                else if (wait_cfg == '0)     state_d = S_DATA;
                else                         state_d = S_WAIT;
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q - WAIT_W'(1);
                if (wait_cnt_q <= WAIT_W'(1)) state_d = S_DATA;
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase

        hgrant_d  = hbusreq | (hgrant_q & hlock);
        hmaster_d = (hgrant_q & hready) ? MASTER_ID : hmaster_q;
    end

    always_comb begin
        hready = 1'b1;
        hresp  = 2'b00;
        rd_vld = 1'b0;
        mem_we = 1'b0;
        case (state_q)
            S_WAIT: begin
                hready = 1'b0;
                rd_vld = ~hwrite_q;
            end
            S_DATA: begin
                rd_vld = ~hwrite_q;
                mem_we = hwrite_q;
            end
            S_ERR1: begin
                hready = 1'b0;
                hresp  = 2'b01;
            end
            S_ERR2:  hresp = 2'b01;
            default: ;
        endcase
    end

    // Equal injection positions OR into the same mask bit, so the bit flips only once.
    assign flip    = flip_mask(inj_a_q) | flip_mask(inj_b_q);
    assign hrdata  = rd_vld ? (ecc_encode(mem_q[idx_q]) ^ flip) : 32'h0;
    assign hgrant  = hgrant_q;
    assign hmaster = hmaster_q;

endmodule

// File: tb/tb_ahb_ecc_mem_responder.sv
// Directed bench for ahb_ecc_mem_responder: hand-computed SECDED codewords, wait/error timing, aliasing, reset and grant.
module tb_ahb_ecc_mem_responder;

    logic        hclk;
    logic        hresetn;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [63:0] hwdata;
    logic        hbusreq;
    logic        hlock;
    logic [3:0]  wait_cfg;
    logic        err_req;
    logic [5:0]  inj_a;
    logic [5:0]  inj_b;
    logic [31:0] hrdata;
    logic        hready;
    logic [1:0]  hresp;
    logic        hgrant;
    logic [3:0]  hmaster;

    int checks = 0;
    int errors = 0;

    ahb_ecc_mem_responder #(.MEM_DEPTH(64), .WAIT_W(4), .MASTER_ID(4'd1)) dut (
        .hclk(hclk), .hresetn(hresetn), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
        .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hbusreq(hbusreq), .hlock(hlock),
        .wait_cfg(wait_cfg), .err_req(err_req), .inj_a(inj_a), .inj_b(inj_b),
        .hrdata(hrdata), .hready(hready), .hresp(hresp), .hgrant(hgrant), .hmaster(hmaster)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick;
        @(posedge hclk);
        #1;
    endtask

    // One isolated transfer; reports data-phase length and first/last-cycle response and data.
    task automatic do_xfer(input logic w, input logic [31:0] addr, input logic [63:0] wdata,
                           input logic [3:0] wc, input logic err, input logic [2:0] size,
                           input logic [5:0] ia, input logic [5:0] ib,
                           output int cyc, output logic [31:0] rd0, output logic [31:0] rd,
                           output logic [1:0] resp0, output logic [1:0] resp_last);
        haddr = addr; htrans = 2'd2; hwrite = w; hsize = size;
        wait_cfg = wc; err_req = err; inj_a = ia; inj_b = ib;
        tick();
        htrans = 2'd0; hwdata = wdata;
        cyc = 0; rd = 32'h0; resp_last = 2'd3;
        resp0 = hresp; rd0 = hrdata;
        for (int i = 0; i < 40; i++) begin
            cyc++;
            if (hready) begin
                rd = hrdata;
                resp_last = hresp;
                tick();
                break;
            end
            tick();
        end
        err_req = 1'b0; inj_a = 6'd0; inj_b = 6'd0; wait_cfg = 4'd0; hsize = 3'b010;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge hclk);
        #1;
        checks++; if (hready !== 1'b1) begin errors++; $display("FAIL rst_hready got %b exp 1", hready); end
        checks++; if (hresp !== 2'd0) begin errors++; $display("FAIL rst_hresp got %0d exp 0", hresp); end
        checks++; if (hrdata !== 32'h0) begin errors++; $display("FAIL rst_hrdata got %h exp 0", hrdata); end
        checks++; if (hgrant !== 1'b0) begin errors++; $display("FAIL rst_hgrant got %b exp 0", hgrant); end
        checks++; if (hmaster !== 4'd0) begin errors++; $display("FAIL rst_hmaster got %0d exp 0", hmaster); end
        hresetn = 1'b1;
        tick();
        htrans = 2'd1; haddr = 32'h0; hwrite = 1'b0;
        tick();
        htrans = 2'd0;
        checks++; if (hready !== 1'b1 || hresp !== 2'd0 || hrdata !== 32'h0)
            begin errors++; $display("FAIL busy_phase got rdy=%b resp=%0d rd=%h exp 1/0/0", hready, hresp, hrdata); end
    endtask

    task automatic test_ecc_read;
        int cyc; logic [31:0] rd0, rd; logic [1:0] r0, r1;
        do_xfer(1'b1, 32'h0, 64'h1, 4'd0, 1'b0, 3'b010, 6'd0, 6'd0, cyc, rd0, rd, r0, r1);
        checks++; if (cyc != 1) begin errors++; $display("FAIL wr0_cycles got %0d exp 1", cyc); end
        do_xfer(1'b0, 32'h0, 64'h0, 4'd0, 1'b0, 3'b010, 6'd0, 6'd0, cyc, rd0, rd, r0, r1);
        checks++; if (rd !== 32'h8000_0007) begin errors++; $display("FAIL rd_plain got %h exp 80000007", rd); end
        checks++; if (r1 !== 2'd0) begin errors++; $display("FAIL rd_plain_resp got %0d exp 0", r1); end
        checks++; if (cyc != 1) begin errors++; $display("FAIL rd_plain_cycles got %0d exp 1", cyc); end
        do_xfer(1'b0, 32'h0, 64'h0, 4'd0, 1'b0, 3'b010, 6'd3, 6'd0, cyc, rd0, rd, r0, r1);
        checks++; if (rd !== 32'h8000_0003) begin errors++; $display("FAIL rd_inj3 got %h exp 80000003", rd); end
        do_xfer(1'b0, 32'h0, 64'h0, 4'd0, 1'b0, 3'b010, 6'd3, 6'd32, cyc, rd0, rd, r0, r1);
        checks++; if (rd !== 32'h0000_0003) begin errors++; $display("FAIL rd_inj3_32 got %h exp 00000003", rd); end
        do_xfer(1'b0, 32'h0, 64'h0, 4'd0, 1'b0, 3'b010, 6'd3, 6'd3, cyc, rd0, rd, r0, r1);
        checks++; if (rd !== 32'h8000_0003) begin errors++; $display("FAIL rd_inj_same got %h exp 80000003", rd); end
        do_xfer(1'b0, 32'h0, 64'h0, 4'd0, 1'b0, 3'b010, 6'd33, 6'd1, cyc, rd0, rd, r0, r1);
        checks++; if (rd !== 32'h8000_0006) begin errors++; $display("FAIL rd_inj33_1 got %h exp 80000006", rd); end
    endtask

    task automatic test_wait_back_to_back;
        int low;
        int cyc; logic [31:0] rd0, rd; logic [1:0] r0, r1;
        haddr = 32'd20; htrans = 2'd2; hwrite = 1'b1; hsize = 3'b010; wait_cfg = 4'd3;
        tick();
        htrans = 2'd0; hwdata = 64'hFFFF_FFFF_FFFF_FFFF; wait_cfg = 4'd0;
        low = 0;
        for (int i = 0; i < 30; i++) begin
            if (hready) break;
            low++;
            tick();
        end
        checks++; if (low != 3) begin errors++; $display("FAIL wait3_low got %0d exp 3", low); end
        // Next address phase overlaps the write's final data cycle.
        haddr = 32'd20; htrans = 2'd2; hwrite = 1'b0;
        tick();
        htrans = 2'd0;
        checks++; if (hready !== 1'b1 || hrdata !== 32'hFFFF_FFFF)
            begin errors++; $display("FAIL b2b_raw got rdy=%b rd=%h exp 1/ffffffff", hready, hrdata); end
        tick();
        do_xfer(1'b0, 32'd20, 64'h0, 4'd15, 1'b0, 3'b010, 6'd0, 6'd0, cyc, rd0, rd, r0, r1);
        checks++; if (cyc != 16) begin errors++; $display("FAIL wait15_cycles got %0d exp 16", cyc); end
        checks++; if (rd0 !== 32'hFFFF_FFFF || rd !== 32'hFFFF_FFFF)
            begin errors++; $display("FAIL wait15_data got %h/%h exp ffffffff", rd0, rd); end
    endtask

    task automatic test_error;
        int cyc; logic [31:0] rd0, rd; logic [1:0] r0, r1;
        do_xfer(1'b1, 32'd8, 64'h123, 4'd5, 1'b1, 3'b010, 6'd0, 6'd0, cyc, rd0, rd, r0, r1);
        checks++; if (cyc != 2) begin errors++; $display("FAIL err_cycles got %0d exp 2", cyc); end
        checks++; if (r0 !== 2'd1 || r1 !== 2'd1) begin errors++; $display("FAIL err_resp got %0d/%0d exp 1/1", r0, r1); end
        checks++; if (rd0 !== 32'h0 || rd !== 32'h0) begin errors++; $display("FAIL err_rdata got %h/%h exp 0/0", rd0, rd); end
        do_xfer(1'b0, 32'd8, 64'h0, 4'd0, 1'b0, 3'b010, 6'd0, 6'd0, cyc, rd0, rd, r0, r1);
        checks++; if (rd !== 32'h0 || r1 !== 2'd0 || cyc != 1)
            begin errors++; $display("FAIL err_nowrite got rd=%h resp=%0d cyc=%0d exp 0/0/1", rd, r1, cyc); end
        do_xfer(1'b1, 32'd8, 64'h123, 4'd0, 1'b0, 3'b000, 6'd0, 6'd0, cyc, rd0, rd, r0, r1);
        checks++; if (cyc != 2 || r0 !== 2'd1 || r1 !== 2'd1)
            begin errors++; $display("FAIL hsize_err got cyc=%0d resp=%0d/%0d exp 2/1/1", cyc, r0, r1); end
        do_xfer(1'b0, 32'd8, 64'h0, 4'd0, 1'b0, 3'b010, 6'd0, 6'd0, cyc, rd0, rd, r0, r1);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL hsize_nowrite got %h exp 0", rd); end
    endtask

    task automatic test_alias;
        int cyc; logic [31:0] rd0, rd; logic [1:0] r0, r1;
        do_xfer(1'b1, 32'h100, 64'h2, 4'd0, 1'b0, 3'b010, 6'd0, 6'd0, cyc, rd0, rd, r0, r1);
        do_xfer(1'b0, 32'h0, 64'h0, 4'd0, 1'b0, 3'b010, 6'd0, 6'd0, cyc, rd0, rd, r0, r1);
        checks++; if (rd !== 32'h8000_0019) begin errors++; $display("FAIL alias got %h exp 80000019", rd); end
    endtask

    task automatic test_reset_mid_wait;
        int cyc; logic [31:0] rd0, rd; logic [1:0] r0, r1;
        hbusreq = 1'b1;
        tick();
        tick();
        haddr = 32'd0; htrans = 2'd2; hwrite = 1'b0; hsize = 3'b010; wait_cfg = 4'd5;
        tick();
        htrans = 2'd0; wait_cfg = 4'd0;
        tick();
        checks++; if (hready !== 1'b0 || hrdata !== 32'h8000_0019 || hgrant !== 1'b1 || hmaster !== 4'd1)
            begin errors++; $display("FAIL pre_rst got rdy=%b rd=%h gnt=%b mst=%0d exp 0/80000019/1/1", hready, hrdata, hgrant, hmaster); end
        hresetn = 1'b0;
        #1;
        checks++; if (hready !== 1'b1 || hresp !== 2'd0 || hrdata !== 32'h0 || hgrant !== 1'b0 || hmaster !== 4'd0)
            begin errors++; $display("FAIL mid_rst got rdy=%b resp=%0d rd=%h gnt=%b mst=%0d exp 1/0/0/0/0", hready, hresp, hrdata, hgrant, hmaster); end
        hbusreq = 1'b0;
        #3;
        hresetn = 1'b1;
        tick();
        do_xfer(1'b0, 32'h0, 64'h0, 4'd0, 1'b0, 3'b010, 6'd0, 6'd0, cyc, rd0, rd, r0, r1);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mem_cleared got %h exp 0", rd); end
        // Write abandoned in WAIT must leave no trace.
        haddr = 32'd12; htrans = 2'd2; hwrite = 1'b1; wait_cfg = 4'd4;
        tick();
        htrans = 2'd0; hwdata = 64'h1; wait_cfg = 4'd0;
        tick();
        hresetn = 1'b0;
        #3;
        hresetn = 1'b1;
        tick();
        do_xfer(1'b0, 32'd12, 64'h0, 4'd0, 1'b0, 3'b010, 6'd0, 6'd0, cyc, rd0, rd, r0, r1);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL lost_write got %h exp 0", rd); end
    endtask

    task automatic test_arbiter;
        hbusreq = 1'b1; hlock = 1'b0;
        tick();
        checks++; if (hgrant !== 1'b1 || hmaster !== 4'd0)
            begin errors++; $display("FAIL gnt_rise got gnt=%b mst=%0d exp 1/0", hgrant, hmaster); end
        hbusreq = 1'b0;
        tick();
        checks++; if (hgrant !== 1'b0 || hmaster !== 4'd1)
            begin errors++; $display("FAIL gnt_fall got gnt=%b mst=%0d exp 0/1", hgrant, hmaster); end
        tick();
        checks++; if (hmaster !== 4'd1) begin errors++; $display("FAIL mst_hold got %0d exp 1", hmaster); end
        hbusreq = 1'b1; hlock = 1'b1;
        tick();
        hbusreq = 1'b0;
        tick();
        checks++; if (hgrant !== 1'b1) begin errors++; $display("FAIL lock_hold1 got %b exp 1", hgrant); end
        tick();
        checks++; if (hgrant !== 1'b1) begin errors++; $display("FAIL lock_hold2 got %b exp 1", hgrant); end
        hlock = 1'b0;
        tick();
        checks++; if (hgrant !== 1'b0) begin errors++; $display("FAIL lock_release got %b exp 0", hgrant); end
    endtask

    initial begin
        hresetn = 1'b0; haddr = '0; htrans = 2'd0; hwrite = 1'b0; hsize = 3'b010; hburst = 3'd0;
        hwdata = '0; hbusreq = 1'b0; hlock = 1'b0; wait_cfg = '0; err_req = 1'b0;
        inj_a = '0; inj_b = '0;
        test_reset();
        test_ecc_read();
        test_wait_back_to_back();
        test_error();
        test_alias();
        test_reset_mid_wait();
        test_arbiter();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
